fence_t_sequencer: RTL and testbench

Sequences a fence.t (timing-channel microarchitectural flush) request from the commit stage into a single-cycle 20-bit flush vector for the flush controller. It tracks the D-cache flush acknowledge when a D-cache flush is selected. It optionally pads the whole operation to a software-programmed constant cycle count. It sits between commit/CSR and the flush controller, and halts commit while a fence.t is in progress.

---
 rtl/fence_t_sequencer.sv | 124 ++++++++++++
 tb/tb_fence_t_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fence_t_sequencer.sv
// fence.t sequencer: turns an accepted commit request into a one-cycle flush vector,
// waits for the D-cache flush ack when selected, and pads to pad_cycles_i when FENCE_T_PAD_EN is defined.
module fence_t_sequencer #(
    parameter int unsigned PadWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                fence_t_valid_i,
    output logic                fence_t_ready_o,
    input  logic [9:0]          fence_t_sel_i,
    input  logic [PadWidth-1:0] pad_cycles_i,
    output logic [19:0]         fence_t_o,
    input  logic                flush_dcache_ack_i,
    output logic                halt_o,
    output logic                fence_t_done_o
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        WAIT_ACK,
        PAD,
        DONE
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] sel_q;
    logic       ack_seen_q, ack_seen_d;
    logic       accept;
    logic       ack_done;

    assign accept   = fence_t_valid_i && (state_q == IDLE);
    assign ack_done = ack_seen_q || flush_dcache_ack_i;

`ifdef FENCE_T_PAD_EN
    logic [PadWidth-1:0] pad_q;
    logic [PadWidth-1:0] elapsed_q;
    logic                pad_reached;
    logic                counting;

    assign pad_reached = (elapsed_q >= pad_q);
    assign counting    = (state_q == FLUSH) || (state_q == WAIT_ACK) || (state_q == PAD);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pad_q     <= '0;
            elapsed_q <= '0;
        end else if (accept) begin
            pad_q     <= pad_cycles_i;
            elapsed_q <= '0;
        end else if (counting && (elapsed_q != '1)) begin
            elapsed_q <= elapsed_q + 1'b1;
        end
    end
`else
    logic unused_pad;
    assign unused_pad = ^pad_cycles_i;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fence_t_valid_i) state_d = FLUSH;
            end
            FLUSH: begin
`ifdef FENCE_T_PAD_EN
                state_d = sel_q[4] ? WAIT_ACK : PAD;
`else
                state_d = sel_q[4] ? WAIT_ACK : DONE;
`endif
            end
            WAIT_ACK: begin
`ifdef FENCE_T_PAD_EN
                if (ack_done) state_d = PAD;
`else
                if (ack_done) state_d = DONE;
`endif
            end
`ifdef FENCE_T_PAD_EN
            PAD: begin
                if (pad_reached) state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ack is only meaningful once the flush vector has been issued.
    always_comb begin
        ack_seen_d = ack_seen_q;
        if (accept) begin
            ack_seen_d = 1'b0;
        end else if (((state_q == FLUSH) || (state_q == WAIT_ACK)) && flush_dcache_ack_i) begin
            ack_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ack_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_seen_q <= ack_seen_d;
            if (accept) sel_q <= fence_t_sel_i;
        end
    end

    always_comb begin
        fence_t_o       = '0;
        fence_t_ready_o = (state_q == IDLE);
        halt_o          = (state_q != IDLE);
        fence_t_done_o  = (state_q == DONE);
        if (state_q == FLUSH) fence_t_o = {10'b0, sel_q};
    end

endmodule

// File: tb/tb_fence_t_sequencer.sv
// Directed scoreboard bench for fence_t_sequencer; expectations follow FENCE_T_PAD_EN.
module tb_fence_t_sequencer;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic [9:0]  sel;
    logic [15:0] pad;
    logic [19:0] fvec;
    logic        ack;
    logic        halt;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] vec;
        int          done_at;
    } exp_t;

    exp_t exp_q[$];

    fence_t_sequencer #(.PadWidth(16)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .fence_t_valid_i    (valid),
        .fence_t_ready_o    (ready),
        .fence_t_sel_i      (sel),
        .pad_cycles_i       (pad),
        .fence_t_o          (fvec),
        .flush_dcache_ack_i (ack),
        .halt_o             (halt),
        .fence_t_done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Cycle (relative to accept cycle T) at which done should pulse.
    function automatic int exp_done(input logic [9:0] s, input int p, input int ack_at);
`ifdef FENCE_T_PAD_EN
        if (!s[4]) return 2 + imax(p, 1);
        return 2 + imax(p, imax(ack_at, 2));
`else
        if (!s[4]) return 2;
        return imax(ack_at, 2) + 1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, {31'b0, ready}, 1);
        check({tag, "_halt"},  {31'b0, halt},  0);
        check({tag, "_done"},  {31'b0, done},  0);
        check({tag, "_fvec"},  {12'b0, fvec},  0);
    endtask

    // Called at a negedge with the DUT idle; drives one request and follows it to completion.
    task automatic do_op(input logic [9:0] s, input int p, input int ack_at,
                         input bit busy_valid, input int abort_at);
        exp_t e;
        bit   got;
        bit   aborted;
        valid = 1'b1;
        sel   = s;
        pad   = p[15:0];
        ack   = 1'b0;
        e.vec     = {10'b0, s};
        e.done_at = exp_done(s, p, ack_at);
        exp_q.push_back(e);
        got     = 1'b0;
        aborted = 1'b0;
        for (int j = 1; j <= 200 && !got && !aborted; j++) begin
            @(negedge clk);
            valid = busy_valid;
            if (abort_at != 0 && j == abort_at + 1) begin
                check_idle("abort");
                void'(exp_q.pop_front());
                rst_n   = 1'b1;
                aborted = 1'b1;
            end else begin
                check("fence_vec", {12'b0, fvec}, (j == 1) ? {12'b0, exp_q[0].vec} : 32'd0);
                check("halt_busy", {31'b0, halt}, 1);
                check("ready_busy", {31'b0, ready}, 0);
                if (done) begin
                    e = exp_q.pop_front();
                    check("done_cycle", j, e.done_at);
                    got = 1'b1;
                end
                ack = (j == ack_at);
                if (j == abort_at) rst_n = 1'b0;
            end
        end
        ack = 1'b0;
        if (!aborted) begin
            check("done_seen", {31'b0, got}, 1);
            @(negedge clk);
            valid = 1'b0;
            check_idle("post_done");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b1;
        sel   = 10'h001;
        pad   = 16'd10;
        ack   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle("reset");
        end
        rst_n = 1'b1;

        do_op(10'h001, 10, 0, 1'b0, 0);
        do_op(10'h001, 0, 0, 1'b0, 0);
        do_op(10'h010, 10, 4, 1'b0, 0);
        do_op(10'h010, 2, 20, 1'b0, 0);
        do_op(10'h010, 2, 1, 1'b0, 0);
        do_op(10'h001, 5, 0, 1'b1, 0);
        do_op(10'h010, 10, 0, 1'b0, 3);

        // An ack while idle must not satisfy the next D-cache flush.
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_idle("idle_ack");
        do_op(10'h010, 0, 6, 1'b0, 0);

        do_op(10'h3FF, 100, 5, 1'b0, 0);
        do_op(10'h000, 3, 0, 1'b0, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
